// File: rtl/alu_exec_unit.sv
// Single-slot ALU execution unit: captures a ready RS slot, computes the result,
// arbitrates for the CDB and broadcasts {tag, data, target} for exactly one cycle.
module alu_exec_unit #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned OP_W   = 5,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              rs_busy,
  input  logic [OP_W-1:0]   rs_op,
  input  logic [TAG_W-1:0]  rs_tagx,
  input  logic [TAG_W-1:0]  rs_tagy,
  input  logic [TAG_W-1:0]  rs_tagw,
  input  logic [WORD_W-1:0] rs_datax,
  input  logic [WORD_W-1:0] rs_datay,
  input  logic [REG_W-1:0]  rs_target,
  input  logic              cdb_gnt,
  output logic              cdb_req,
  output logic              ex_busy,
  output logic [TAG_W-1:0]  ex_tag,
  output logic [WORD_W-1:0] ex_data,
  output logic [REG_W-1:0]  ex_target
);

  localparam logic [TAG_W-1:0] UNLOCKED = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_REQ   = 2'd2;
  localparam logic [1:0] S_BCAST = 2'd3;

  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(8);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_PASSY = OP_W'(10);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              w_capture;

  logic [OP_W-1:0]   r_op;
  logic [WORD_W-1:0] r_datax;
  logic [WORD_W-1:0] r_datay;
  logic [TAG_W-1:0]  r_tagw;
  logic [REG_W-1:0]  r_target;
  logic [WORD_W-1:0] r_result;
  logic [WORD_W-1:0] w_alu;
  logic [4:0]        w_shamt;

  logic              r_cdb_req;
  logic              r_ex_busy;
  logic [TAG_W-1:0]  r_ex_tag;
  logic [WORD_W-1:0] r_ex_data;
  logic [REG_W-1:0]  r_ex_target;

  // State register
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= S_IDLE;
    end else if (rdy) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; capture only when both operands are ready
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rs_busy && (rs_tagx == UNLOCKED) && (rs_tagy == UNLOCKED)) begin
          w_state_nxt = S_EXEC;
          w_capture   = 1'b1;
        end
      end
      S_EXEC:  w_state_nxt = S_REQ;
      S_REQ:   if (cdb_gnt) w_state_nxt = S_BCAST;
      S_BCAST: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_shamt = r_datay[4:0];

  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:   w_alu = r_datax + r_datay;
      OP_SUB:   w_alu = r_datax - r_datay;
      OP_SLL:   w_alu = r_datax << w_shamt;
      OP_SLT:   w_alu = WORD_W'($signed(r_datax) < $signed(r_datay));
      OP_SLTU:  w_alu = WORD_W'(r_datax < r_datay);
      OP_XOR:   w_alu = r_datax ^ r_datay;
      OP_SRL:   w_alu = r_datax >> w_shamt;
      OP_SRA:   w_alu = WORD_W'($signed(r_datax) >>> w_shamt);
      OP_OR:    w_alu = r_datax | r_datay;
      OP_AND:   w_alu = r_datax & r_datay;
      OP_PASSY: w_alu = r_datay;
      default:  w_alu = '0;
    endcase
  end

  // Operand latch, result register and registered outputs tracking the next state
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_op        <= '0;
      r_datax     <= '0;
      r_datay     <= '0;
      r_tagw      <= UNLOCKED;
      r_target    <= '0;
      r_result    <= '0;
      r_cdb_req   <= 1'b0;
      r_ex_busy   <= 1'b1;
      r_ex_tag    <= UNLOCKED;
      r_ex_data   <= '0;
      r_ex_target <= '0;
    end else if (rdy) begin
      if (w_capture) begin
        r_op     <= rs_op;
        r_datax  <= rs_datax;
        r_datay  <= rs_datay;
        r_tagw   <= rs_tagw;
        r_target <= rs_target;
      end
      if (r_state == S_EXEC) begin
        r_result <= w_alu;
      end
      r_cdb_req   <= (w_state_nxt == S_REQ);
      r_ex_busy   <= (w_state_nxt != S_BCAST);
      r_ex_tag    <= (w_state_nxt == S_BCAST) ? r_tagw   : UNLOCKED;
      r_ex_data   <= (w_state_nxt == S_BCAST) ? r_result : '0;
      r_ex_target <= (w_state_nxt == S_BCAST) ? r_target : '0;
    end
  end

  assign cdb_req   = r_cdb_req;
  assign ex_busy   = r_ex_busy;
  assign ex_tag    = r_ex_tag;
  assign ex_data   = r_ex_data;
  assign ex_target = r_ex_target;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: broadcasts are scored against a queue of
// expected {tag, data, target} pushed when each instruction is issued.
module tb_alu_exec_unit;

  localparam logic [3:0] UNL = 4'hF;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        flush;
  logic        rs_busy;
  logic [4:0]  rs_op;
  logic [3:0]  rs_tagx;
  logic [3:0]  rs_tagy;
  logic [3:0]  rs_tagw;
  logic [31:0] rs_datax;
  logic [31:0] rs_datay;
  logic [4:0]  rs_target;
  logic        cdb_gnt;
  logic        cdb_req;
  logic        ex_busy;
  logic [3:0]  ex_tag;
  logic [31:0] ex_data;
  logic [4:0]  ex_target;

  logic [40:0] sb_q[$];
  int total;
  int bad;
  int bcast_cnt;
  int n_pushed;
  int bc_before;

  alu_exec_unit dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .flush     (flush),
    .rs_busy   (rs_busy),
    .rs_op     (rs_op),
    .rs_tagx   (rs_tagx),
    .rs_tagy   (rs_tagy),
    .rs_tagw   (rs_tagw),
    .rs_datax  (rs_datax),
    .rs_datay  (rs_datay),
    .rs_target (rs_target),
    .cdb_gnt   (cdb_gnt),
    .cdb_req   (cdb_req),
    .ex_busy   (ex_busy),
    .ex_tag    (ex_tag),
    .ex_data   (ex_data),
    .ex_target (ex_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every broadcast cycle pops one expected payload
  always @(negedge clk) begin
    logic [40:0] e;
    if (!rst && ex_busy === 1'b0) begin
      bcast_cnt++;
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL bcast_unexpected observed=%0h expected=none", {ex_tag, ex_data, ex_target});
      end else begin
        e = sb_q.pop_front();
        chk("bcast_payload", 64'({ex_tag, ex_data, ex_target}), 64'(e));
      end
    end
  end

  // Drive one ready instruction at a negedge; returns at the next negedge (EXEC)
  task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [3:0] tw, input logic [4:0] tg, input logic [31:0] res,
                       input bit push);
    rs_op = op; rs_datax = x; rs_datay = y; rs_tagw = tw; rs_target = tg;
    rs_tagx = UNL; rs_tagy = UNL; rs_busy = 1'b1;
    if (push) begin
      sb_q.push_back({tw, res, tg});
      n_pushed++;
    end
    @(negedge clk);
    rs_busy = 1'b0; rs_datax = 32'hDEAD_BEEF; rs_datay = 32'h1234_5678; rs_op = 5'd1;
  endtask

  // Immediate-grant flow: EXEC, REQ, one BCAST cycle, back to idle outputs
  task automatic run_op(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [3:0] tw, input logic [4:0] tg, input logic [31:0] res);
    issue(op, x, y, tw, tg, res, 1'b1);
    chk("exec_req", 64'(cdb_req), 64'(0));
    chk("exec_busy", 64'(ex_busy), 64'(1));
    @(negedge clk);
    chk("req_req", 64'(cdb_req), 64'(1));
    @(negedge clk);
    chk("bcast_busy", 64'(ex_busy), 64'(0));
    chk("bcast_req", 64'(cdb_req), 64'(0));
    @(negedge clk);
    chk("post_busy", 64'(ex_busy), 64'(1));
    chk("post_tag", 64'(ex_tag), 64'(UNL));
    chk("post_data", 64'(ex_data), 64'(0));
  endtask

  initial begin
    total = 0; bad = 0; bcast_cnt = 0; n_pushed = 0;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; rs_busy = 1'b0; rs_op = '0;
    rs_tagx = UNL; rs_tagy = UNL; rs_tagw = '0; rs_datax = '0; rs_datay = '0;
    rs_target = '0; cdb_gnt = 1'b1;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_req", 64'(cdb_req), 64'(0));
    chk("rst_busy", 64'(ex_busy), 64'(1));
    chk("rst_tag", 64'(ex_tag), 64'(UNL));
    chk("rst_data", 64'(ex_data), 64'(0));
    chk("rst_target", 64'(ex_target), 64'(0));

    run_op(5'd0,  32'hFFFF_FFFF, 32'h0000_0002, 4'd3, 5'd7,  32'h0000_0001);
    run_op(5'd1,  32'h0000_0000, 32'h0000_0001, 4'd1, 5'd2,  32'hFFFF_FFFF);
    run_op(5'd2,  32'h0000_0001, 32'h0000_003F, 4'd2, 5'd3,  32'h8000_0000);
    run_op(5'd3,  32'hFFFF_FFFF, 32'h0000_0001, 4'd4, 5'd4,  32'h0000_0001);
    run_op(5'd3,  32'h0000_0001, 32'hFFFF_FFFF, 4'd5, 5'd5,  32'h0000_0000);
    run_op(5'd4,  32'hFFFF_FFFF, 32'h0000_0001, 4'd6, 5'd6,  32'h0000_0000);
    run_op(5'd4,  32'h0000_0001, 32'hFFFF_FFFF, 4'd7, 5'd8,  32'h0000_0001);
    run_op(5'd5,  32'hF0F0_F0F0, 32'hFF00_FF00, 4'd8, 5'd9,  32'h0FF0_0FF0);
    run_op(5'd6,  32'h8000_0000, 32'h0000_0024, 4'd9, 5'd10, 32'h0800_0000);
    run_op(5'd7,  32'h8000_0000, 32'h0000_0004, 4'd10, 5'd11, 32'hF800_0000);
    run_op(5'd8,  32'h0F00_0000, 32'h0000_00F0, 4'd11, 5'd12, 32'h0F00_00F0);
    run_op(5'd9,  32'hF0F0_F0F0, 32'hFF00_FF00, 4'd12, 5'd13, 32'hF000_F000);
    run_op(5'd10, 32'h1234_5678, 32'hABCD_0000, 4'd13, 5'd14, 32'hABCD_0000);
    run_op(5'd15, 32'h0000_0005, 32'h0000_0006, 4'd14, 5'd15, 32'h0000_0000);

    // Locked operand x: no capture for 4 cycles, then capture on unlock
    rs_op = 5'd0; rs_datax = 32'd5; rs_datay = 32'd6; rs_tagw = 4'd2; rs_target = 5'd1;
    rs_tagx = 4'd5; rs_tagy = UNL; rs_busy = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("locked_req", 64'(cdb_req), 64'(0));
      chk("locked_busy", 64'(ex_busy), 64'(1));
    end
    rs_tagx = UNL;
    sb_q.push_back({4'd2, 32'd11, 5'd1});
    n_pushed++;
    @(negedge clk);
    rs_busy = 1'b0;
    chk("unlock_exec_req", 64'(cdb_req), 64'(0));
    @(negedge clk);
    chk("unlock_req", 64'(cdb_req), 64'(1));
    @(negedge clk);
    chk("unlock_bcast", 64'(ex_busy), 64'(0));
    @(negedge clk);

    // Grant stall: 5 cycles in REQ without grant
    cdb_gnt = 1'b0;
    issue(5'd0, 32'd10, 32'd20, 4'd4, 5'd9, 32'd30, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_req", 64'(cdb_req), 64'(1));
      chk("stall_busy", 64'(ex_busy), 64'(1));
    end
    cdb_gnt = 1'b1;
    @(negedge clk);
    chk("stall_bcast", 64'(ex_busy), 64'(0));
    chk("stall_bcast_req", 64'(cdb_req), 64'(0));
    @(negedge clk);
    chk("stall_post", 64'(ex_busy), 64'(1));

    // Flush while requesting: request withdrawn, nothing broadcast
    bc_before = bcast_cnt;
    cdb_gnt = 1'b0;
    issue(5'd0, 32'd1, 32'd1, 4'd6, 5'd6, 32'd2, 1'b0);
    @(negedge clk);
    chk("flush_pre_req", 64'(cdb_req), 64'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    cdb_gnt = 1'b1;
    chk("flush_req", 64'(cdb_req), 64'(0));
    chk("flush_busy", 64'(ex_busy), 64'(1));
    chk("flush_tag", 64'(ex_tag), 64'(UNL));
    repeat (4) begin
      @(negedge clk);
      chk("flush_no_bcast", 64'(ex_busy), 64'(1));
    end
    chk("flush_bcast_cnt", 64'(bcast_cnt), 64'(bc_before));
    run_op(5'd0, 32'd100, 32'd23, 4'd9, 5'd17, 32'd123);

    // Freeze: rdy=0 for 3 cycles in EXEC, then 2 cycles in REQ with grant high
    issue(5'd5, 32'h0000_FFFF, 32'h00FF_00FF, 4'd11, 5'd21, 32'h00FF_FF00, 1'b1);
    rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("frz_exec_req", 64'(cdb_req), 64'(0));
      chk("frz_exec_busy", 64'(ex_busy), 64'(1));
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("frz_resume_req", 64'(cdb_req), 64'(1));
    rdy = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("frz_req_req", 64'(cdb_req), 64'(1));
      chk("frz_req_busy", 64'(ex_busy), 64'(1));
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("frz_bcast", 64'(ex_busy), 64'(0));
    @(negedge clk);
    chk("frz_post", 64'(ex_busy), 64'(1));

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'(0));
    chk("bcast_count", 64'(bcast_cnt), 64'(n_pushed));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
